// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO streaming stages: skid-buffer occupancy encoding and depth.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_state_t;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_drain_stage.sv
// Drains a shift-register FIFO into a registered valid/ready stream via a two-entry skid buffer.
// Pops are issued only when the FIFO is non-empty and a slot is guaranteed free.
module fifo_drain_stage
  import fifo_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drain_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
);

  occ_state_t       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;
  logic             deq;

  // Pop depends only on registered occupancy and FIFO status, never on out_ready.
  // Gating with rst_n keeps the strobe low while reset is held.
  assign pop       = rst_n & drain_en & ~fifo_empty & (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign deq       = out_valid & out_ready;

  assign fifo_pop  = pop;
  assign out_data  = head_q;
  assign out_cnt   = cnt_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;

    if (deq) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_EMPTY: begin
        if (pop) begin
          state_d = S_ONE;
          head_d  = fifo_data;
        end
      end
      S_ONE: begin
        if (pop && deq) begin
          head_d = fifo_data;
        end else if (pop) begin
          state_d = S_TWO;
          tail_d  = fifo_data;
        end else if (deq) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (deq) begin
          state_d = S_ONE;
          head_d  = tail_q;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_stage.sv
// Directed bench for fifo_drain_stage with a queue-based FIFO model on the read side.
module tb_fifo_drain_stage;
  import fifo_stream_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             drain_en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_pop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_cnt;

  logic             pop4;
  logic             valid4;
  logic [WIDTH-1:0] data4;
  logic [3:0]       cnt4;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] rx[$];
  int               nvec;
  int               nerr;
  int               pop_cnt;
  logic             bad_pop;

  fifo_drain_stage #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .drain_en  (drain_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  // Narrow-counter copy sharing all inputs; only its out_cnt wrap is checked.
  fifo_drain_stage #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .drain_en  (drain_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (pop4),
    .out_valid (valid4),
    .out_ready (out_ready),
    .out_data  (data4),
    .out_cnt   (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_data  = fifo_empty ? '0 : q[0];
  endtask

  // One clock: sample at negedge, pop the model just after the rising edge.
  task automatic cyc();
    logic p;
    @(negedge clk);
    p = fifo_pop;
    if (p && fifo_empty) bad_pop = 1'b1;
    if (p) pop_cnt++;
    if (out_valid && out_ready) rx.push_back(out_data);
    @(posedge clk);
    #1;
    if (p) void'(q.pop_front());
    refresh();
  endtask

  initial begin
    nvec = 0; nerr = 0; pop_cnt = 0; bad_pop = 1'b0;
    rst_n = 1'b0; drain_en = 1'b1; out_ready = 1'b1;
    q = '{8'h11, 8'h22, 8'h33};
    refresh();
    #1;
    check_eq("rst_pop", 32'(fifo_pop), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_cnt", 32'(out_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Preloaded three words, free-running drain.
    cyc();
    check_eq("t1_d0", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
    cyc();
    check_eq("t1_d1", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
    cyc();
    check_eq("t1_d2", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h33});
    cyc();
    check_eq("t1_idle", 32'(out_valid), 32'd0);
    check_eq("t1_cnt", 32'(out_cnt), 32'd3);
    check_eq("t1_nopop_empty", 32'(bad_pop), 32'd0);

    // Backpressure: five words, consumer stalled.
    out_ready = 1'b0;
    pop_cnt = 0;
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    refresh();
    repeat (4) cyc();
    check_eq("t2_pops", 32'(pop_cnt), 32'd2);
    check_eq("t2_pop_low", 32'(fifo_pop), 32'd0);
    check_eq("t2_state", 32'(dut.state_q), 32'(S_TWO));
    check_eq("t2_hold", 32'(out_data), 32'h01);
    check_eq("t2_fifo_left", 32'(q.size()), 32'd3);
    out_ready = 1'b1;
    rx.delete();
    repeat (8) cyc();
    check_eq("t2_rx_n", 32'(rx.size()), 32'd5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("t2_rx%0d", i), 32'(rx[i]), 32'(i + 1));
    check_eq("t2_cnt", 32'(out_cnt), 32'd8);

    // Simultaneous pop and deq in S_ONE.
    out_ready = 1'b0;
    q = '{8'hA0};
    refresh();
    cyc();
    q.push_back(8'hB0);
    refresh();
    out_ready = 1'b1;
    check_eq("t3_pre_state", 32'(dut.state_q), 32'(S_ONE));
    check_eq("t3_pre_pop", 32'(fifo_pop), 32'd1);
    cyc();
    check_eq("t3_state", 32'(dut.state_q), 32'(S_ONE));
    check_eq("t3_head", 32'(out_data), 32'hB0);
    check_eq("t3_cnt", 32'(out_cnt), 32'd9);
    cyc();
    check_eq("t3_cnt2", 32'(out_cnt), 32'd10);

    // drain_en dropped while full with FIFO still non-empty.
    out_ready = 1'b0;
    q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    refresh();
    repeat (3) cyc();
    check_eq("t4_full", 32'(dut.state_q), 32'(S_TWO));
    drain_en = 1'b0;
    out_ready = 1'b1;
    pop_cnt = 0;
    rx.delete();
    repeat (4) cyc();
    check_eq("t4_pops", 32'(pop_cnt), 32'd0);
    check_eq("t4_rx_n", 32'(rx.size()), 32'd2);
    check_eq("t4_rx0", 32'(rx[0]), 32'hC1);
    check_eq("t4_rx1", 32'(rx[1]), 32'hC2);
    check_eq("t4_state", 32'(dut.state_q), 32'(S_EMPTY));
    check_eq("t4_cnt", 32'(out_cnt), 32'd12);

    // Asynchronous reset mid-cycle while full.
    drain_en = 1'b1;
    out_ready = 1'b0;
    repeat (2) cyc();
    check_eq("t5_full", 32'(dut.state_q), 32'(S_TWO));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_valid", 32'(out_valid), 32'd0);
    check_eq("t5_cnt", 32'(out_cnt), 32'd0);
    check_eq("t5_pop", 32'(fifo_pop), 32'd0);
    q.delete();
    q = '{8'hD5, 8'hD6};
    refresh();
    rst_n = 1'b1;
    out_ready = 1'b1;
    rx.delete();
    repeat (3) cyc();
    check_eq("t5_rx_n", 32'(rx.size()), 32'd2);
    check_eq("t5_first", 32'(rx[0]), 32'hD5);
    check_eq("t5_second", 32'(rx[1]), 32'hD6);

    // 17 handshakes: 4-bit counter wraps to 1.
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_cnt4", 32'(cnt4), 32'd0);
    q.delete();
    for (int i = 0; i < 17; i++) q.push_back(8'(i));
    refresh();
    rst_n = 1'b1;
    rx.delete();
    repeat (20) cyc();
    check_eq("t6_rx_n", 32'(rx.size()), 32'd17);
    check_eq("t6_rx16", 32'(rx[16]), 32'd16);
    check_eq("t6_cnt8", 32'(out_cnt), 32'd17);
    check_eq("t6_cnt4", 32'(cnt4), 32'd1);
    check_eq("all_nopop_empty", 32'(bad_pop), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_drain_stage.md
# fifo_drain_stage

Downstream stage of the shift-register FIFO. Converts the FIFO's pop/empty/data_out read port into a registered valid/ready stream through a two-entry skid buffer. Issues `fifo_pop` only when the FIFO is non-empty and buffer space is guaranteed, so the no-pop-when-empty environment rule always holds. Sits between `shift_register_fifo` and any valid/ready consumer, and shares the FIFO's clock and reset.

## Interface
- `WIDTH`, default 8: data word width; must match the FIFO's `WIDTH`.
- `CNT_W`, default 8: width of the delivered-word counter.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
- `drain_en`  in  1  permits new pops from the FIFO when high; words already buffered still drain when low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO head word; valid combinationally whenever `fifo_empty` is 0.
- `fifo_pop`  out  1  pop strobe to the FIFO; the head word is consumed on the same edge.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  consumer accepts the word on this edge when `out_valid` is also high.
- `out_data`  out  WIDTH  oldest buffered word.
- `out_cnt`  out  CNT_W  count of completed output handshakes; wraps modulo 2^CNT_W.

## Operation
- The state is the buffer occupancy: S_EMPTY (0), S_ONE (1), S_TWO (2). Slot `head` drives `out_data`; slot `tail` is the skid slot.
- `fifo_pop = drain_en & ~fifo_empty & (state != S_TWO)`. This is a function of registered state and inputs only; there is no path from `out_ready`.
- `out_valid = (state != S_EMPTY)`.
- `deq = out_valid & out_ready`.
- Transitions:
  - S_EMPTY: pop → S_ONE with `head` ← `fifo_data`.
  - S_ONE, pop & deq → S_ONE with `head` ← `fifo_data`.
  - S_ONE, pop & ~deq → S_TWO with `tail` ← `fifo_data`.
  - S_ONE, ~pop & deq → S_EMPTY.
  - S_TWO, deq → S_ONE with `head` ← `tail`.
  - No other transitions; state holds otherwise.
- Order is strictly FIFO. No word is duplicated or dropped except by reset.
- `out_cnt` increments by 1 on every `deq` and wraps from 2^CNT_W−1 to 0.
- `head` and `tail` are not written on idle cycles. `out_data` holds stable while `out_valid & ~out_ready`.
- Dropping `drain_en` mid-stream stops pops on the next evaluation. Buffered words remain deliverable.

## Timing
- Reset values (asynchronous, while `rst_n` = 0): state S_EMPTY, `out_valid` 0, `out_data` 0, `tail` 0, `out_cnt` 0. `fifo_pop` is 0 during reset.
- Latency: a word popped at edge N appears on `out_data` with `out_valid` high after edge N.
- Steady-state throughput is 1 word/cycle when `out_ready` is held high and the FIFO is non-empty.
- Backpressure: at most two pops occur after `out_ready` falls before `fifo_pop` deasserts.
- Reset mid-operation discards both slots. The FIFO is cleared by the same reset.
- Boundary cases:
  - S_TWO with `fifo_empty` = 0: no pop.
  - S_EMPTY with `fifo_empty` = 1: idle.
  - Simultaneous pop and deq in S_ONE: occupancy is unchanged and the new word becomes `head`.

## Structure
- Shared package `fifo_stream_pkg`:
  - `occ_state_t` enum {S_EMPTY, S_ONE, S_TWO}, 2-bit encoding.
  - Constant `SKID_DEPTH = 2`.
- No sub-module; the stage is one flat module.
- A formal wrapper in the FIFO-harness style instantiates the FIFO, this stage and the scoreboard. Its end-to-end data-integrity assertion covers the full path.

## Test plan
- Reset release, FIFO preloaded with 0x11, 0x22, 0x33, `out_ready` = 1, `drain_en` = 1 → `out_data` shows 0x11, 0x22, 0x33 on three consecutive cycles after the first pop; `out_cnt` = 3; `fifo_pop` never high while `fifo_empty` = 1.
- FIFO holds 5 words, `out_ready` = 0 → exactly 2 pops, then `fifo_pop` stays 0 with state S_TWO. Raising `out_ready` → 5 words delivered in order.
- S_ONE with `fifo_empty` = 0 and `out_ready` = 1 → pop and deq on the same edge; state stays S_ONE; `out_cnt` increments by 1.
- `drain_en` dropped in S_TWO with the FIFO non-empty → no further pops; 2 buffered words drain; state ends S_EMPTY.
- `rst_n` asserted asynchronously mid-cycle in S_TWO → `out_valid` falls immediately; `out_cnt` = 0; after release the first word out is the FIFO's new head.
- `CNT_W` = 4, 17 handshakes → `out_cnt` = 1.
